sev_seg_scan: RTL and testbench

Parametrised, time-multiplexed driver for a multi-digit common-anode seven-segment display. It extends the single-digit display decoder to N digits with registered inputs. It adds an extended glyph set, per-digit decimal point, per-digit blink, and a global enable. It sits between the control FSM, which supplies digit codes, and the board-level segment and anode pins.

---
 rtl/sev_seg_pkg.sv | 24 ++
 rtl/sev_seg_scan_if.sv | 26 ++
 rtl/sev_seg_glyph.sv | 20 ++
 rtl/sev_seg_scan.sv | 91 +++++++++
 tb/tb_sev_seg_scan.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/sev_seg_pkg.sv
// Shared constants for the multiplexed seven-segment driver.
// Glyph bytes are active-low {dp,g,f,e,d,c,b,a} with dp off.
package sev_seg_pkg;

    localparam int CODE_W = 5;

    typedef logic [CODE_W-1:0] code_t;

    localparam code_t CODE_H     = 5'h10;
    localparam code_t CODE_DASH  = 5'h11;
    localparam code_t CODE_BLANK = 5'h1F;

    localparam logic [7:0] GLYPH_BLANK = 8'hFF;
    localparam logic [7:0] GLYPH_H     = 8'h89;
    localparam logic [7:0] GLYPH_DASH  = 8'hBF;

    localparam logic [0:15][7:0] GLYPH_HEX = {
        8'hC0, 8'hF9, 8'hA4, 8'hB0,
        8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83,
        8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/sev_seg_scan_if.sv
// Controller-facing bundle of the display driver.
// master = code supplier, slave = sev_seg_scan.
interface sev_seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    import sev_seg_pkg::*;

    logic                               load;
    logic [NUM_DIGITS-1:0][CODE_W-1:0]  digits_in;
    logic [NUM_DIGITS-1:0]              dp_in;
    logic [NUM_DIGITS-1:0]              blink_en;
    logic                               enable;
    logic [7:0]                         seg_out;
    logic [NUM_DIGITS-1:0]              an_out;

    modport master (
        output load, digits_in, dp_in, blink_en, enable,
        input  seg_out, an_out
    );

    modport slave (
        input  load, digits_in, dp_in, blink_en, enable,
        output seg_out, an_out
    );

endinterface

// File: rtl/sev_seg_glyph.sv
// 5-bit glyph code to active-low g..a segment pattern.
// Hex 0-F, H, dash; every other code is blank.
module sev_seg_glyph
    import sev_seg_pkg::*;
(
    input  code_t      i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = GLYPH_BLANK[6:0];
        unique case (1'b1)
            (i_code[4] == 1'b0):   o_seg = GLYPH_HEX[i_code[3:0]][6:0];
            (i_code == CODE_H):    o_seg = GLYPH_H[6:0];
            (i_code == CODE_DASH): o_seg = GLYPH_DASH[6:0];
            default:               o_seg = GLYPH_BLANK[6:0];
        endcase
    end

endmodule

// File: rtl/sev_seg_scan.sv
// Time-multiplexed N-digit common-anode driver with shadowed
// codes, per-digit dp and blink, and a global blanking enable.
module sev_seg_scan
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 12500000
)(
    input  logic         clk,
    input  logic         rst_n,
    sev_seg_scan_if.slave bus
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [NUM_DIGITS-1:0][CODE_W-1:0] r_code;
    logic [NUM_DIGITS-1:0]             r_dp;
    logic [NUM_DIGITS-1:0]             r_blink;
    logic [PW-1:0]                     r_pre;
    logic [IW-1:0]                     r_idx;
    logic [BW-1:0]                     r_bcnt;
    logic                              r_phase;
    logic [7:0]                        r_seg;
    logic [NUM_DIGITS-1:0]             r_an;

    logic       w_pre_wrap;
    logic       w_idx_wrap;
    logic       w_bcnt_wrap;
    logic       w_dark;
    logic [6:0] w_glyph;

    assign w_pre_wrap  = (r_pre == PW'(SCAN_DIV - 1));
    assign w_idx_wrap  = (r_idx == IW'(NUM_DIGITS - 1));
    assign w_bcnt_wrap = (r_bcnt == BW'(BLINK_DIV - 1));
    assign w_dark      = r_phase & r_blink[r_idx];

    sev_seg_glyph u_glyph (
        .i_code (r_code[r_idx]),
        .o_seg  (w_glyph)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code  <= {NUM_DIGITS{CODE_BLANK}};
            r_dp    <= '0;
            r_blink <= '0;
        end else if (bus.load) begin
            r_code  <= bus.digits_in;
            r_dp    <= bus.dp_in;
            r_blink <= bus.blink_en;
        end
    end

    // Counters freeze while blanked so scanning resumes in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_idx   <= '0;
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (bus.enable) begin
            r_pre <= w_pre_wrap ? '0 : r_pre + PW'(1);
            if (w_pre_wrap)
                r_idx <= w_idx_wrap ? '0 : r_idx + IW'(1);
            r_bcnt <= w_bcnt_wrap ? '0 : r_bcnt + BW'(1);
            if (w_bcnt_wrap)
                r_phase <= ~r_phase;
        end
    end

    // Anode and segments come from the same index in one register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= GLYPH_BLANK;
            r_an  <= '1;
        end else if (!bus.enable) begin
            r_seg <= GLYPH_BLANK;
            r_an  <= '1;
        end else begin
            r_an  <= ~(NUM_DIGITS'(1) << r_idx);
            r_seg <= w_dark ? GLYPH_BLANK : {~r_dp[r_idx], w_glyph};
        end
    end

    assign bus.seg_out = r_seg;
    assign bus.an_out  = r_an;

endmodule

// File: tb/tb_sev_seg_scan.sv
// Directed + randomized bench for sev_seg_scan against a
// tick-count reference model of the scanned display.
module tb_sev_seg_scan;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int BD = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    sev_seg_scan_if #(.NUM_DIGITS(N)) bus ();

    sev_seg_scan #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (SD),
        .BLINK_DIV  (BD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Model: enabled edges since reset plus the shadowed digit data.
    int         ticks;
    logic [4:0] m_code  [N];
    logic       m_dp    [N];
    logic       m_blink [N];

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [6:0] ref_glyph(input logic [4:0] c);
        logic [6:0] hex [16];
        hex = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        if (c < 5'd16)  return hex[c[3:0]];
        if (c == 5'h10) return 7'h09;
        if (c == 5'h11) return 7'h3F;
        return 7'h7F;
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s t=%0t: observed %h expected %h",
                   tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        ticks = 0;
        for (int k = 0; k < N; k++) begin
            m_code[k]  = 5'h1F;
            m_dp[k]    = 1'b0;
            m_blink[k] = 1'b0;
        end
    endtask

    // One clock: predict from pre-edge state, advance model, compare.
    task automatic cycle(input string tag);
        logic [7:0]   es;
        logic [N-1:0] ea;
        int           idx;
        if (!bus.enable) begin
            es = 8'hFF;
            ea = '1;
        end else begin
            idx = (ticks / SD) % N;
            ea  = ~(N'(1) << idx);
            if (((ticks / BD) % 2 == 1) && m_blink[idx])
                es = 8'hFF;
            else
                es = {~m_dp[idx], ref_glyph(m_code[idx])};
        end
        @(posedge clk);
        if (bus.enable) ticks++;
        if (bus.load) begin
            for (int k = 0; k < N; k++) begin
                m_code[k]  = bus.digits_in[k];
                m_dp[k]    = bus.dp_in[k];
                m_blink[k] = bus.blink_en[k];
            end
        end
        #1;
        check({tag, "_seg"}, 32'(bus.seg_out), 32'(es));
        check({tag, "_an"},  32'(bus.an_out),  32'(ea));
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    task automatic load_once(input string tag,
                             input logic [N-1:0][4:0] codes,
                             input logic [N-1:0] dp,
                             input logic [N-1:0] bl);
        bus.digits_in = codes;
        bus.dp_in     = dp;
        bus.blink_en  = bl;
        bus.load      = 1'b1;
        cycle(tag);
        bus.load      = 1'b0;
    endtask

    // Reset asserted between edges; outputs must blank before next edge.
    task automatic async_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_seg"}, 32'(bus.seg_out), 32'h0000_00FF);
        check({tag, "_rst_an"},  32'(bus.an_out),  32'h0000_000F);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0][4:0] rc;
        bus.load      = 1'b0;
        bus.digits_in = '0;
        bus.dp_in     = '0;
        bus.blink_en  = '0;
        bus.enable    = 1'b1;
        model_reset();

        #2;
        async_reset("init");
        run("blank", 6);

        load_once("t1", {5'h03, 5'h02, 5'h01, 5'h00}, 4'b0000, 4'b0000);
        run("t1", 20);

        load_once("t2", {5'h15, 5'h11, 5'h01, 5'h10}, 4'b0001, 4'b0000);
        run("t2", 16);

        load_once("t3", {5'h0F, 5'h0E, 5'h0D, 5'h0A}, 4'b0000, 4'b0001);
        run("t3", 40);

        for (int i = 0; i < 64 && !(((ticks / SD) % N == 2)
                                    && (ticks % SD == 1)); i++)
            cycle("t4_seek");
        bus.enable = 1'b0;
        run("t4_off", 10);
        bus.enable = 1'b1;
        run("t4_on", 12);

        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 8 && (ticks % SD != SD - 1); i++)
                cycle("t5_seek");
            for (int k = 0; k < N; k++) rc[k] = 5'($urandom_range(31, 0));
            load_once("t5", rc, 4'($urandom), 4'($urandom));
            run("t5", 3);
        end

        for (int i = 0; i < 300; i++) begin
            bus.enable = ($urandom_range(7, 0) != 0);
            bus.load   = ($urandom_range(3, 0) == 0);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(1, 0) == 0)
                    rc[k] = 5'($urandom_range(18, 0));
                else
                    rc[k] = 5'($urandom_range(31, 0));
            end
            bus.digits_in = rc;
            bus.dp_in     = 4'($urandom);
            bus.blink_en  = 4'($urandom);
            cycle("rand");
        end
        bus.load   = 1'b0;
        bus.enable = 1'b1;

        run("t6_pre", 7);
        async_reset("t6");
        run("t6_blank", 9);
        load_once("t6_load", {5'h08, 5'h11, 5'h10, 5'h0B}, 4'b1010, 4'b0000);
        run("t6_post", 16);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
